// File: rtl/router_pkt_tx.sv
// Router packet source: buffers a whole payload, then sends header {len,addr}, payload and parity.
// Latency: the header appears the cycle after the last payload byte is written; each byte takes one busy==0 edge.
// Backpressure: busy==1 holds data_out/pkt_valid; cmd_ready only in IDLE, pl_ready only in FILL.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       cmd_bad_parity,
    input  logic       pl_valid,
    input  logic [7:0] pl_data,
    output logic       pl_ready,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_done,
    output logic       cmd_err
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      addr_q, addr_nxt;
    logic [5:0]      len_q, len_nxt;
    logic            bad_q, bad_nxt;
    logic [7:0]      par_q, par_nxt;
    logic [5:0]      cnt_q, cnt_nxt;
    logic [5:0]      idx_q, idx_nxt;
    logic [GW-1:0]   gap_q, gap_nxt;
    logic [7:0]      dout_nxt;
    logic            pv_nxt;
    logic            tx_done_nxt;
    logic            cmd_err_nxt;
    logic [7:0]      buf_rd;

    logic [7:0]      buf_mem [0:62];

    assign cmd_ready = (state == IDLE);
    assign pl_ready  = (state == FILL);
    assign buf_rd    = buf_mem[idx_q];

    // Payload storage needs no reset; every byte read is written first.
    always_ff @(posedge clock) begin
        if (state == FILL && pl_valid) begin
            buf_mem[cnt_q] <= pl_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            bad_q     <= 1'b0;
            par_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            data_out  <= '0;
            pkt_valid <= 1'b0;
            tx_done   <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_q    <= addr_nxt;
            len_q     <= len_nxt;
            bad_q     <= bad_nxt;
            par_q     <= par_nxt;
            cnt_q     <= cnt_nxt;
            idx_q     <= idx_nxt;
            gap_q     <= gap_nxt;
            data_out  <= dout_nxt;
            pkt_valid <= pv_nxt;
            tx_done   <= tx_done_nxt;
            cmd_err   <= cmd_err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr_q;
        len_nxt     = len_q;
        bad_nxt     = bad_q;
        par_nxt     = par_q;
        cnt_nxt     = cnt_q;
        idx_nxt     = idx_q;
        gap_nxt     = gap_q;
        dout_nxt    = data_out;
        pv_nxt      = pkt_valid;
        tx_done_nxt = 1'b0;
        cmd_err_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_addr == 2'd3 || cmd_len == 6'd0) begin
                        cmd_err_nxt = 1'b1;
                    end else begin
                        addr_nxt  = cmd_addr;
                        len_nxt   = cmd_len;
                        bad_nxt   = cmd_bad_parity;
                        par_nxt   = {cmd_len, cmd_addr};
                        cnt_nxt   = '0;
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                if (pl_valid) begin
                    par_nxt = par_q ^ pl_data;
                    cnt_nxt = cnt_q + 6'd1;
                    if (cnt_q == len_q - 6'd1) begin
                        dout_nxt  = {len_q, addr_q};
                        pv_nxt    = 1'b1;
                        idx_nxt   = '0;
                        state_nxt = HEADER;
                    end
                end
            end
            HEADER: begin
                // idx_q is 0 here, so buf_rd is the first payload byte.
                if (!busy) begin
                    dout_nxt  = buf_rd;
                    idx_nxt   = 6'd1;
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!busy) begin
                    if (idx_q < len_q) begin
                        dout_nxt = buf_rd;
                        idx_nxt  = idx_q + 6'd1;
                    end else begin
                        dout_nxt  = par_q ^ {8{bad_q}};
                        pv_nxt    = 1'b0;
                        state_nxt = PARITY;
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    tx_done_nxt = 1'b1;
                    dout_nxt    = '0;
                    gap_nxt     = '0;
                    state_nxt   = GAP;
                end
            end
            GAP: begin
                // Keeps the router out of parity check before the next header.
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_q + GW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: drives and samples on the falling edge.
module tb_router_pkt_tx;

    typedef logic [7:0] byte_q_t [$];

    logic       clock = 1'b0;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       cmd_bad_parity;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_done;
    logic       cmd_err;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    router_pkt_tx #(.GAP_CYCLES(2)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_bad_parity (cmd_bad_parity),
        .pl_valid       (pl_valid),
        .pl_data        (pl_data),
        .pl_ready       (pl_ready),
        .busy           (busy),
        .data_out       (data_out),
        .pkt_valid      (pkt_valid),
        .tx_done        (tx_done),
        .cmd_err        (cmd_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] a, input logic [5:0] l, input logic b);
        int n = 0;
        cmd_valid      = 1'b1;
        cmd_addr       = a;
        cmd_len        = l;
        cmd_bad_parity = b;
        while (!cmd_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check_eq("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic fill(input byte_q_t d, input bit toggle);
        int  i  = 0;
        int  n  = 0;
        bit  ph = 1'b1;
        check_eq("pl_ready_fill", {31'd0, pl_ready}, 32'd1);
        while (i < d.size() && n < 1000) begin
            pl_valid = toggle ? ph : 1'b1;
            pl_data  = pl_valid ? d[i] : 8'hEE;
            ph       = ~ph;
            if (pl_valid && pl_ready) i++;
            @(negedge clock);
            n++;
        end
        pl_valid = 1'b0;
        check_eq("fill_count", i, d.size());
    endtask

    // Header plus payload with an optional stall on one byte, then parity and gap.
    task automatic rx_packet(input string tag, input logic [7:0] hdr, input byte_q_t pl,
                             input logic [7:0] par, input logic [7:0] xor_exp,
                             input int stall_idx, input int stall_n);
        byte_q_t    e;
        logic [7:0] x = 8'h00;
        int         reps;
        e = pl;
        e.push_front(hdr);
        pl_valid = 1'b1;
        pl_data  = 8'hFF;
        for (int k = 0; k < e.size(); k++) begin
            reps = (k == stall_idx) ? stall_n : 0;
            for (int s = 0; s <= reps; s++) begin
                busy = (s < reps);
                check_eq($sformatf("%s_b%0d", tag, k), {24'd0, data_out}, {24'd0, e[k]});
                check_eq($sformatf("%s_pv%0d", tag, k), {31'd0, pkt_valid}, 32'd1);
                @(negedge clock);
            end
            x = x ^ e[k];
        end
        busy = 1'b0;
        check_eq({tag, "_parity"}, {24'd0, data_out}, {24'd0, par});
        check_eq({tag, "_parity_pv"}, {31'd0, pkt_valid}, 32'd0);
        x = x ^ data_out;
        check_eq({tag, "_xor_all"}, {24'd0, x}, {24'd0, xor_exp});
        @(negedge clock);
        pl_valid = 1'b0;
        check_eq({tag, "_tx_done"}, {31'd0, tx_done}, 32'd1);
        check_eq({tag, "_gap_dout"}, {24'd0, data_out}, 32'd0);
        check_eq({tag, "_gap_pv"}, {31'd0, pkt_valid}, 32'd0);
        check_eq({tag, "_gap_rdy0"}, {31'd0, cmd_ready}, 32'd0);
        @(negedge clock);
        check_eq({tag, "_tx_done_pulse"}, {31'd0, tx_done}, 32'd0);
        check_eq({tag, "_gap_rdy1"}, {31'd0, cmd_ready}, 32'd0);
        @(negedge clock);
        check_eq({tag, "_idle_rdy"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        byte_q_t p1;
        byte_q_t p63;
        p1 = '{8'hA5, 8'h3C, 8'h0F};
        for (int i = 0; i < 63; i++) p63.push_back(8'(i));

        resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        cmd_bad_parity = 1'b0; pl_valid = 1'b0; pl_data = '0; busy = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_dout", {24'd0, data_out}, 32'd0);
        check_eq("rst_pv", {31'd0, pkt_valid}, 32'd0);
        check_eq("rst_tx_done", {31'd0, tx_done}, 32'd0);
        check_eq("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        check_eq("rst_pl_ready", {31'd0, pl_ready}, 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Basic packet, no stalls
        send_cmd(2'd1, 6'd3, 1'b0);
        fill(p1, 1'b0);
        rx_packet("t1", 8'h0D, p1, 8'h9B, 8'h00, -1, 0);

        // Three-cycle stall while 3C is presented
        send_cmd(2'd1, 6'd3, 1'b0);
        fill(p1, 1'b0);
        rx_packet("t2", 8'h0D, p1, 8'h9B, 8'h00, 2, 3);

        // Illegal commands are dropped
        send_cmd(2'd3, 6'd5, 1'b0);
        check_eq("t3a_cmd_err", {31'd0, cmd_err}, 32'd1);
        check_eq("t3a_pl_ready", {31'd0, pl_ready}, 32'd0);
        check_eq("t3a_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clock);
        check_eq("t3a_err_pulse", {31'd0, cmd_err}, 32'd0);
        send_cmd(2'd0, 6'd0, 1'b0);
        check_eq("t3b_cmd_err", {31'd0, cmd_err}, 32'd1);
        check_eq("t3b_pv", {31'd0, pkt_valid}, 32'd0);
        @(negedge clock);
        check_eq("t3b_err_pulse", {31'd0, cmd_err}, 32'd0);
        check_eq("t3b_pl_ready", {31'd0, pl_ready}, 32'd0);

        // Maximum length, pl_valid toggling; header FE, parity FE^3F = C1
        send_cmd(2'd2, 6'd63, 1'b0);
        fill(p63, 1'b1);
        rx_packet("t4", 8'hFE, p63, 8'hC1, 8'h00, 40, 2);

        // Parity error injection
        send_cmd(2'd1, 6'd3, 1'b1);
        fill(p1, 1'b0);
        rx_packet("t5", 8'h0D, p1, 8'h64, 8'hFF, -1, 0);

        // Reset while in PAYLOAD, then a clean packet
        send_cmd(2'd1, 6'd3, 1'b0);
        fill(p1, 1'b0);
        check_eq("t6_hdr", {24'd0, data_out}, 32'h0D);
        busy = 1'b0;
        @(negedge clock);
        check_eq("t6_first", {24'd0, data_out}, 32'hA5);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check_eq("t6_rst_pv", {31'd0, pkt_valid}, 32'd0);
        check_eq("t6_rst_dout", {24'd0, data_out}, 32'd0);
        check_eq("t6_rst_rdy", {31'd0, cmd_ready}, 32'd1);
        send_cmd(2'd1, 6'd3, 1'b0);
        fill(p1, 1'b0);
        rx_packet("t6", 8'h0D, p1, 8'h9B, 8'h00, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
